// File: rtl/serial_sub_unit.sv
// Bit-serial unsigned subtractor: one operand bit per clock, LSB first.
// Result and final borrow are published together with a one-cycle done pulse.
module serial_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa, opb, res;
    logic             br;
    logic             ai, bi, d, br_nx;
    logic [WIDTH-1:0] res_nx;

    assign ai     = opa[0];
    assign bi     = opb[0];
    assign d      = ai ^ bi ^ br;
    assign br_nx  = (~ai & bi) | (~(ai ^ bi) & br);
    assign res_nx = {d, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            res        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    br  <= br_nx;
                    res <= res_nx;
                    cnt <= cnt + 1'b1;
                    // last bit: publish the completed result straight from the shift path
                    if (cnt == LAST) begin
                        diff       <= res_nx;
                        borrow_out <= br_nx;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_unit.sv
// Randomized bench for serial_sub_unit against an arithmetic reference (a-b, a<b).
module tb_serial_sub_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] diff;
    logic         borrow_out, busy, done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_diff = '0;
    logic         last_br   = 1'b0;

    serial_sub_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .diff(diff), .borrow_out(borrow_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One full operation; optionally scrambles a/b/start while busy.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit disturb);
        int n;
        bit seen;
        logic [W:0] ref_full;
        logic [W-1:0] ref_diff;
        logic ref_br;
        ref_full = {1'b0, ta} - {1'b0, tb_v};
        ref_diff = ref_full[W-1:0];
        ref_br   = (ta < tb_v);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 0;
        seen = 0;
        while (!seen && n < W + 4) begin
            if (disturb) begin
                @(negedge clk);
                a = W'($urandom); b = W'($urandom); start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
            else begin
                chk("busy_run", busy, 1);
                chk("diff_hold", diff, last_diff);
                chk("borrow_hold", borrow_out, last_br);
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency_edges", n + 1, W + 1);
        chk("diff", diff, ref_diff);
        chk("borrow_out", borrow_out, ref_br);
        chk("busy_at_done", busy, 0);
        last_diff = ref_diff;
        last_br   = ref_br;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        @(posedge clk); #1;
        chk("no_requeue", busy, 0);
        chk("diff_idle_hold", diff, last_diff);
    endtask

    initial begin
        logic [W-1:0] corner_a [4];
        logic [W-1:0] corner_b [4];
        corner_a = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        corner_b = '{8'hFF, 8'h00, 8'hFF, 8'h00};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #2;
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // idle with start low holds everything
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end

        run_op(8'h5A, 8'h3C, 0);
        run_op(8'h00, 8'h01, 0);
        run_op(8'h80, 8'h80, 0);
        run_op(8'h10, 8'h01, 1);

        // asynchronous reset mid-operation
        @(negedge clk);
        a = 8'hFF; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (10) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        last_diff = '0;
        last_br   = 1'b0;
        run_op(8'h07, 8'h09, 0);

        for (int i = 0; i < 4; i++) run_op(corner_a[i], corner_b[i], 0);
        for (int i = 0; i < 1000; i++)
            run_op(W'($urandom), W'($urandom), bit'($urandom_range(0, 3) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub_unit.md
SERIAL_SUB_UNIT -- requirements
Module: serial_sub_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, unsigned.
REQ-007 The block SHALL have port diff, output, WIDTH bits: registered result a-b modulo 2^WIDTH.
REQ-008 The block SHALL have port borrow_out, output, 1 bit: final borrow; 1 iff a<b.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that diff and borrow_out have been updated.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE, and SHALL use a bit counter of ceil(log2(WIDTH)) bits, an operand shift register pair, a result shift register and a borrow flip-flop.
REQ-012 In IDLE with start=1 at edge E0, the block SHALL latch a and b, clear the borrow flip-flop, clear the bit counter, and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL hold all state.
REQ-014 At each RUN edge Ei (i=1..WIDTH), the block SHALL process operand bit i-1 (LSB first) as follows:
- d = ai ^ bi ^ br
- br_next = (~ai & bi) | (~(ai ^ bi) & br)
- d is shifted into the result shift register from the MSB end.
REQ-015 At edge E(WIDTH), the block SHALL enter DONE, load diff from the completed result shift register, load borrow_out from br_next, and assert done.
REQ-016 At the edge following DONE, the block SHALL return to IDLE and deassert done.
- done SHALL be high for exactly one cycle.
- Total latency SHALL be WIDTH+1 edges from the start-sampling edge to the done-asserting edge.
REQ-017 busy SHALL equal 1 exactly when the state is RUN.
REQ-018 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued; back-to-back operations therefore require start to be high in IDLE.
REQ-019 Changes on a or b after E0 SHALL NOT affect the operation in progress.
REQ-020 diff and borrow_out SHALL hold their last published values through IDLE and RUN, changing only on the DONE-entry edge.
REQ-021 When a==b, the block SHALL produce diff=0 and borrow_out=0.

Reset
REQ-022 When rst_n=0, the block SHALL immediately, without waiting for clk, force:
- state to IDLE;
- diff, borrow_out, busy and done to 0;
- the counter, shift registers and borrow flip-flop to 0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no update of diff.
REQ-024 After rst_n rises, the first start sampled high in IDLE SHALL begin a normal operation.

Verification (WIDTH=8)
REQ-025 a=0x5A, b=0x3C, one-cycle start -> busy for 8 cycles, then done pulse with diff=0x1E, borrow_out=0, on the 9th edge after start.
REQ-026 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; then a=0x80, b=0x80 -> diff=0x00, borrow_out=0.
REQ-027 start pulsed again, and a/b changed, while busy (a=0x10, b=0x01 started first) -> single done pulse with diff=0x0F only; no second operation.
REQ-028 rst_n driven low asynchronously at bit 4 of a=0xFF, b=0x01 -> outputs 0 immediately, no done pulse; a following start with a=0x07, b=0x09 -> diff=0xFE, borrow_out=1.
REQ-029 Random test of 1000 (a,b) pairs, including 0x00/0xFF corners -> diff==(a-b) mod 256 and borrow_out==(a<b) on every done, with exactly WIDTH+1 edges of latency.
